// File: rtl/booth_pp_accumulator_seq.sv
// Iterative radix-4 Booth multiplier: one recoded digit of Mant_b per cycle, accumulated
// into a two's-complement running sum; exact unsigned product presented with valid/ready.
module booth_pp_accumulator_seq #(
    parameter int unsigned C_MANT = 23
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RI,
    input  logic                  Flush_SI,
    input  logic                  In_valid_SI,
    output logic                  In_ready_SO,
    input  logic [C_MANT:0]       Mant_a_DI,
    input  logic [C_MANT:0]       Mant_b_DI,
    output logic                  Out_valid_SO,
    input  logic                  Out_ready_SI,
    output logic [2*C_MANT+1:0]   Prod_DO,
    output logic                  Busy_SO
);

    localparam int unsigned C_NUM_PP = (C_MANT + 3) / 2;
    localparam int unsigned ACC_W    = 2 * C_MANT + 4;
    localparam int unsigned PROD_W   = 2 * C_MANT + 2;
    localparam int unsigned BEXT_W   = C_MANT + 4;
    localparam int unsigned CNT_W    = $clog2(C_NUM_PP);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t              state_q;
    logic [C_MANT:0]     a_q;
    logic [BEXT_W-1:0]   b_ext_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_next;
    logic [ACC_W-1:0]    mag;
    logic [CNT_W-1:0]    cnt_q;
    logic [PROD_W-1:0]   prod_q;
    logic [2:0]          digit;
    logic                neg;
    logic                last_digit;

    assign In_ready_SO  = (state_q == IDLE);
    assign Out_valid_SO = (state_q == DONE);
    assign Busy_SO      = (state_q == BUSY);
    assign Prod_DO      = prod_q;
    assign last_digit   = (cnt_q == CNT_W'(C_NUM_PP - 1));

    // Digit window B_ext[2k+2:2k]; the partial product is formed as a magnitude
    // and then added or subtracted, so no explicit sign-extension scheme is needed.
    always_comb begin
        digit = 3'(b_ext_q >> {cnt_q, 1'b0});
        mag   = '0;
        neg   = 1'b0;
        unique case (digit)
            3'b001, 3'b010: mag = {{(ACC_W-C_MANT-1){1'b0}}, a_q};
            3'b011:         mag = {{(ACC_W-C_MANT-2){1'b0}}, a_q, 1'b0};
            3'b100: begin
                mag = {{(ACC_W-C_MANT-2){1'b0}}, a_q, 1'b0};
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                mag = {{(ACC_W-C_MANT-1){1'b0}}, a_q};
                neg = 1'b1;
            end
            default:        mag = '0;
        endcase
        mag      = mag << {cnt_q, 1'b0};
        acc_next = neg ? (acc_q - mag) : (acc_q + mag);
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            a_q     <= '0;
            b_ext_q <= '0;
        end else if (Flush_SI) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (In_valid_SI) begin
                        a_q     <= Mant_a_DI;
                        b_ext_q <= {2'b00, Mant_b_DI, 1'b0};
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_digit) begin
                        prod_q  <= acc_next[PROD_W-1:0];
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (Out_ready_SI) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_pp_accumulator_seq.sv
// Self-checking bench for booth_pp_accumulator_seq: directed corner products, backpressure,
// flush/reset aborts, then random operands compared against plain integer multiplication.
module tb_booth_pp_accumulator_seq;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] mant_a;
    logic [23:0] mant_b;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] prod;
    logic        busy;

    int unsigned errors;
    int unsigned checks;

    booth_pp_accumulator_seq #(.C_MANT(23)) dut (
        .Clk_CI       (clk),
        .Rst_RI       (rst),
        .Flush_SI     (flush),
        .In_valid_SI  (in_valid),
        .In_ready_SO  (in_ready),
        .Mant_a_DI    (mant_a),
        .Mant_b_DI    (mant_b),
        .Out_valid_SO (out_valid),
        .Out_ready_SI (out_ready),
        .Prod_DO      (prod),
        .Busy_SO      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] model_mul(input logic [23:0] a, input logic [23:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return p[47:0];
    endfunction

    // Accept one operand pair at the next edge; returns at the negedge after acceptance.
    task automatic accept(input logic [23:0] a, input logic [23:0] b, input string tag);
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        mant_a   = a;
        mant_b   = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        mant_a   = $urandom();
        mant_b   = $urandom();
        check({tag, "_busy"}, {62'd0, busy, in_ready}, 64'b10);
    endtask

    task automatic run_op(input logic [23:0] a, input logic [23:0] b, input int stall, input string tag);
        logic [47:0] exp;
        logic [47:0] held;
        int n;
        exp = model_mul(a, b);
        out_ready = 1'b0;
        accept(a, b, tag);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd13);
        check({tag, "_prod"}, 64'(prod), 64'(exp));
        held = prod;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "_stall"}, {13'd0, out_valid, in_ready, busy, prod}, {13'd0, 3'b100, held});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_release"}, {61'd0, out_valid, in_ready, busy}, 64'b010);
    endtask

    initial begin
        int seen;
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mant_a    = '0;
        mant_b    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_outputs", {13'd0, in_ready, out_valid, busy, prod}, {13'd0, 3'b100, 48'd0});

        run_op(24'h800000, 24'h800000, 0, "msb_sq");
        check("msb_sq_const", 64'(prod), 64'h4000_0000_0000);
        run_op(24'hFFFFFF, 24'hFFFFFF, 0, "all_ones");
        check("all_ones_const", 64'(prod), 64'hFFFF_FE00_0001);
        run_op(24'hABCDEF, 24'h000000, 0, "zero_b");
        run_op(24'h000001, 24'hAAAAAA, 0, "one_x_aa");
        check("one_x_aa_const", 64'(prod), 64'h0000_00AA_AAAA);
        run_op(24'h123456, 24'h654321, 20, "backpressure");

        // Flush while in IDLE must block acceptance.
        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_idle_block", {62'd0, in_ready, busy}, 64'b10);

        // Flush at BUSY cnt=6: abort, no product presented.
        accept(24'h777777, 24'h333333, "flush_op");
        repeat (6) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_abort", {61'd0, in_ready, busy, out_valid}, 64'b100);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_no_valid", 64'(seen), 64'd0);

        // Reset at BUSY cnt=3: abort and clear the product register.
        accept(24'h555555, 24'hAAAAAA, "rst_op");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_abort", {13'd0, in_ready, busy, out_valid, prod}, {13'd0, 3'b100, 48'd0});
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_no_valid", 64'(seen), 64'd0);

        run_op(24'hC00000, 24'hC00000, 0, "after_abort");
        check("after_abort_const", 64'(prod), 64'h9000_0000_0000);

        for (int i = 0; i < 1000; i++) begin
            logic [23:0] ra;
            logic [23:0] rb;
            ra = 24'($urandom());
            rb = 24'($urandom());
            if (i % 97 == 0) ra = 24'hFFFFFF;
            if (i % 89 == 0) rb = 24'h000000;
            run_op(ra, rb, int'($urandom_range(0, 3)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
